spi_burst_ctrl: RTL and testbench

SPI_BURST_CTRL -- requirements
Module: spi_burst_ctrl

---
 rtl/spi_burst_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_spi_burst_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer between host command/data streams and an SPI master, with write and read FIFOs.
// Define SPI_BURST_CTRL_ERR_STATUS_EN to enable the sticky underrun/overflow status flags.
module spi_burst_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 15,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic                  i_cmd_rw,
  input  logic [15:0]           i_cmd_len,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic                  o_spi_enable,
  output logic [ADDR_WIDTH-1:0] o_spi_addr,
  output logic [DATA_WIDTH-1:0] o_spi_data,
  output logic                  o_spi_rw,
  output logic                  o_spi_burst_enable,
  output logic [15:0]           o_spi_burst_count,
  input  logic                  i_spi_busy,
  input  logic                  i_spi_word_request,
  input  logic                  i_spi_read_valid,
  input  logic [DATA_WIDTH-1:0] i_spi_read_word,
  output logic                  o_underrun,
  output logic                  o_overflow,
  input  logic                  i_err_clear,
  output logic                  o_idle
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, PREFILL, START, RUN, DONE} state_t;

  state_t                state_r;
  logic [15:0]           len_r;
  logic                  rw_r;
  logic                  req_q_r, valid_q_r, busy_q_r;
  logic [DATA_WIDTH-1:0] wr_mem_r [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rd_mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_wp_r, wr_rp_r, rd_wp_r, rd_rp_r;
  logic [CW-1:0]         wr_cnt_r, rd_cnt_r;

  logic        wr_empty_s, wr_full_s, rd_empty_s, rd_full_s;
  logic        wr_push_s, wr_pop_req_s, wr_pop_s;
  logic        rd_push_req_s, rd_push_s, rd_pop_s;
  logic        req_rise_s, valid_rise_s, busy_fall_s, cmd_accept_s;
  logic [16:0] rd_free_s;

  assign wr_empty_s = (wr_cnt_r == '0);
  assign wr_full_s  = (wr_cnt_r == CW'(FIFO_DEPTH));
  assign rd_empty_s = (rd_cnt_r == '0);
  assign rd_full_s  = (rd_cnt_r == CW'(FIFO_DEPTH));
  assign rd_free_s  = 17'(FIFO_DEPTH) - 17'(rd_cnt_r);

  assign req_rise_s   = i_spi_word_request && !req_q_r;
  assign valid_rise_s = i_spi_read_valid && !valid_q_r;
  assign busy_fall_s  = busy_q_r && !i_spi_busy;

  // A read is held off until the read FIFO can absorb the whole burst
  assign o_cmd_ready  = (state_r == IDLE) &&
                        !(i_cmd_valid && i_cmd_rw && (rd_free_s < {1'b0, i_cmd_len}));
  assign cmd_accept_s = i_cmd_valid && o_cmd_ready;
  assign o_idle       = (state_r == IDLE);

  assign wr_push_s    = i_wr_valid && !wr_full_s;
  assign wr_pop_req_s = !rw_r && (((state_r == START) && i_spi_busy) ||
                                  ((state_r == RUN) && req_rise_s));
  assign wr_pop_s     = wr_pop_req_s && !wr_empty_s;

  assign rd_pop_s      = i_rd_ready && !rd_empty_s;
  assign rd_push_req_s = (state_r == RUN) && rw_r &&
                         ((len_r > 16'd1) ? valid_rise_s : busy_fall_s);
  assign rd_push_s     = rd_push_req_s && (!rd_full_s || rd_pop_s);

  assign o_wr_ready = !wr_full_s;
  assign o_rd_valid = !rd_empty_s;
  assign o_rd_data  = rd_empty_s ? '0 : rd_mem_r[rd_rp_r];
  assign o_spi_data = wr_empty_s ? '0 : wr_mem_r[wr_rp_r];

  // Command sequencing and registered SPI control outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r            <= IDLE;
      len_r              <= 16'd0;
      rw_r               <= 1'b0;
      o_spi_enable       <= 1'b0;
      o_spi_addr         <= '0;
      o_spi_rw           <= 1'b0;
      o_spi_burst_enable <= 1'b0;
      o_spi_burst_count  <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_accept_s) begin
            len_r      <= i_cmd_len;
            rw_r       <= i_cmd_rw;
            o_spi_addr <= i_cmd_addr;
            o_spi_rw   <= i_cmd_rw;
            if (i_cmd_len == 16'd0) begin
              state_r <= DONE;
            end else if (i_cmd_rw) begin
              state_r            <= START;
              o_spi_enable       <= 1'b1;
              o_spi_burst_enable <= (i_cmd_len > 16'd1);
              o_spi_burst_count  <= (i_cmd_len > 16'd1) ? i_cmd_len : 16'd0;
            end else begin
              state_r <= PREFILL;
            end
          end
        end
        PREFILL: begin
          if (!wr_empty_s) begin
            state_r            <= START;
            o_spi_enable       <= 1'b1;
            o_spi_burst_enable <= (len_r > 16'd1);
            o_spi_burst_count  <= (len_r > 16'd1) ? len_r : 16'd0;
          end
        end
        START: begin
          if (i_spi_busy) begin
            o_spi_enable <= 1'b0;
            state_r      <= RUN;
          end
        end
        RUN: begin
          if (busy_fall_s) state_r <= DONE;
        end
        DONE: begin
          state_r            <= IDLE;
          o_spi_burst_enable <= 1'b0;
          o_spi_burst_count  <= 16'd0;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy counters and SPI status edge detectors
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_wp_r   <= '0;
      wr_rp_r   <= '0;
      wr_cnt_r  <= '0;
      rd_wp_r   <= '0;
      rd_rp_r   <= '0;
      rd_cnt_r  <= '0;
      req_q_r   <= 1'b0;
      valid_q_r <= 1'b0;
      busy_q_r  <= 1'b0;
    end else begin
      if (wr_push_s) wr_wp_r <= wr_wp_r + PW'(1);
      if (wr_pop_s)  wr_rp_r <= wr_rp_r + PW'(1);
      if (rd_push_s) rd_wp_r <= rd_wp_r + PW'(1);
      if (rd_pop_s)  rd_rp_r <= rd_rp_r + PW'(1);
      wr_cnt_r  <= wr_cnt_r + CW'(wr_push_s) - CW'(wr_pop_s);
      rd_cnt_r  <= rd_cnt_r + CW'(rd_push_s) - CW'(rd_pop_s);
      req_q_r   <= i_spi_word_request;
      valid_q_r <= i_spi_read_valid;
      busy_q_r  <= i_spi_busy;
    end
  end

  // FIFO storage; contents are meaningless outside the pointer window
  always_ff @(posedge i_clk) begin
    if (wr_push_s) wr_mem_r[wr_wp_r] <= i_wr_data;
    if (rd_push_s) rd_mem_r[rd_wp_r] <= i_spi_read_word;
  end

`ifdef SPI_BURST_CTRL_ERR_STATUS_EN
  logic underrun_set_s, overflow_set_s;
  assign underrun_set_s = wr_pop_req_s && wr_empty_s;
  assign overflow_set_s = rd_push_req_s && rd_full_s && !rd_pop_s;

  // Sticky error flags; a clear takes priority over a same-cycle set
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_underrun <= 1'b0;
      o_overflow <= 1'b0;
    end else if (i_err_clear) begin
      o_underrun <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (underrun_set_s) o_underrun <= 1'b1;
      if (overflow_set_s) o_overflow <= 1'b1;
    end
  end
`else
  logic err_clear_unused_s;
  assign err_clear_unused_s = i_err_clear;
  assign o_underrun = 1'b0;
  assign o_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Self-checking bench for spi_burst_ctrl: scripted SPI master model with write/read data scoreboards.
module tb_spi_burst_ctrl;
  localparam int DW = 16;
  localparam int AW = 15;
  localparam int FD = 16;
`ifdef SPI_BURST_CTRL_ERR_STATUS_EN
  localparam logic [31:0] ERR_EN = 32'd1;
`else
  localparam logic [31:0] ERR_EN = 32'd0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_cmd_valid, o_cmd_ready, i_cmd_rw;
  logic [AW-1:0] i_cmd_addr;
  logic [15:0]   i_cmd_len;
  logic [DW-1:0] i_wr_data, o_rd_data, o_spi_data, i_spi_read_word;
  logic          i_wr_valid, o_wr_ready, o_rd_valid, i_rd_ready;
  logic          o_spi_enable, o_spi_rw, o_spi_burst_enable;
  logic [AW-1:0] o_spi_addr;
  logic [15:0]   o_spi_burst_count;
  logic          i_spi_busy, i_spi_word_request, i_spi_read_valid;
  logic          o_underrun, o_overflow, i_err_clear, o_idle;

  spi_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_addr(i_cmd_addr),
    .i_cmd_rw(i_cmd_rw), .i_cmd_len(i_cmd_len),
    .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
    .o_spi_enable(o_spi_enable), .o_spi_addr(o_spi_addr), .o_spi_data(o_spi_data),
    .o_spi_rw(o_spi_rw), .o_spi_burst_enable(o_spi_burst_enable),
    .o_spi_burst_count(o_spi_burst_count),
    .i_spi_busy(i_spi_busy), .i_spi_word_request(i_spi_word_request),
    .i_spi_read_valid(i_spi_read_valid), .i_spi_read_word(i_spi_read_word),
    .o_underrun(o_underrun), .o_overflow(o_overflow), .i_err_clear(i_err_clear),
    .o_idle(o_idle)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] wr_q [$];
  logic [DW-1:0] rd_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic host_push(input logic [DW-1:0] d);
    i_wr_data  = d;
    i_wr_valid = 1'b1;
    wr_q.push_back(d);
    tick();
    i_wr_valid = 1'b0;
  endtask

  task automatic issue_cmd(input logic [AW-1:0] a, input logic rw, input logic [15:0] len);
    int n = 0;
    i_cmd_addr  = a;
    i_cmd_rw    = rw;
    i_cmd_len   = len;
    i_cmd_valid = 1'b1;
    #1;
    while (!o_cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check_eq("cmd_ready", 32'(o_cmd_ready), 32'd1);
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_enable();
    int n = 0;
    while (!o_spi_enable && n < 10) begin
      tick();
      n++;
    end
    check_eq("spi_enable", 32'(o_spi_enable), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!o_idle && n < 10) begin
      tick();
      n++;
    end
    check_eq("idle", 32'(o_idle), 32'd1);
  endtask

  // Compare the word the SPI master is about to take against the host scoreboard
  task automatic spi_capture(input string tag);
    logic [DW-1:0] e;
    if (wr_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'(o_spi_data), 32'hFFFF_FFFF);
    end else begin
      e = wr_q.pop_front();
      check_eq(tag, 32'(o_spi_data), 32'(e));
    end
  endtask

  task automatic spi_start(input logic is_write);
    i_spi_busy = 1'b1;
    if (is_write) spi_capture("wr_first");
    tick();
    check_eq("enable_dropped", 32'(o_spi_enable), 32'd0);
  endtask

  task automatic spi_request(input logic capture);
    i_spi_word_request = 1'b1;
    if (capture) spi_capture("wr_next");
    tick();
    i_spi_word_request = 1'b0;
    tick();
  endtask

  task automatic spi_read_word(input logic [DW-1:0] w, input logic keep);
    i_spi_read_word  = w;
    i_spi_read_valid = 1'b1;
    if (keep) rd_q.push_back(w);
    tick();
    i_spi_read_valid = 1'b0;
    tick();
  endtask

  task automatic spi_end();
    i_spi_busy = 1'b0;
    tick();
    wait_idle();
  endtask

  task automatic drain_rd();
    int n = 0;
    logic [DW-1:0] e;
    i_rd_ready = 1'b1;
    while (o_rd_valid && n < 40) begin
      if (rd_q.size() == 0) begin
        check_eq("rd_extra_word", 32'(o_rd_valid), 32'd0);
        break;
      end
      e = rd_q.pop_front();
      check_eq("rd_data", 32'(o_rd_data), 32'(e));
      tick();
      n++;
    end
    i_rd_ready = 1'b0;
    check_eq("rd_sb_drained", 32'(rd_q.size()), 32'd0);
  endtask

  initial begin
    i_rst = 1'b1;
    i_cmd_valid = 1'b0; i_cmd_rw = 1'b0; i_cmd_addr = '0; i_cmd_len = 16'd0;
    i_wr_data = '0; i_wr_valid = 1'b0; i_rd_ready = 1'b0;
    i_spi_busy = 1'b0; i_spi_word_request = 1'b0; i_spi_read_valid = 1'b0;
    i_spi_read_word = '0; i_err_clear = 1'b0;
    tick();
    tick();
    check_eq("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check_eq("rst_idle", 32'(o_idle), 32'd1);
    check_eq("rst_wr_ready", 32'(o_wr_ready), 32'd1);
    check_eq("rst_enable", 32'(o_spi_enable), 32'd0);
    check_eq("rst_rd_valid", 32'(o_rd_valid), 32'd0);
    check_eq("rst_spi_data", 32'(o_spi_data), 32'd0);
    check_eq("rst_errs", {30'd0, o_underrun, o_overflow}, 32'd0);
    i_rst = 1'b0;
    tick();

    // Single-word write
    host_push(16'hBEEF);
    issue_cmd(15'h1234, 1'b0, 16'd1);
    wait_enable();
    check_eq("a_burst_en", 32'(o_spi_burst_enable), 32'd0);
    check_eq("a_addr", 32'(o_spi_addr), 32'h1234);
    check_eq("a_rw", 32'(o_spi_rw), 32'd0);
    spi_start(1'b1);
    spi_end();
    check_eq("a_wr_empty", 32'(o_spi_data), 32'd0);
    check_eq("a_enable_off", 32'(o_spi_enable), 32'd0);

    // Four-word write burst
    for (int i = 1; i <= 4; i++) host_push(DW'(i));
    issue_cmd(15'h0010, 1'b0, 16'd4);
    wait_enable();
    check_eq("b_burst_en", 32'(o_spi_burst_enable), 32'd1);
    check_eq("b_burst_cnt", 32'(o_spi_burst_count), 32'd4);
    spi_start(1'b1);
    for (int i = 0; i < 3; i++) spi_request(1'b1);
    check_eq("b_burst_cnt_hold", 32'(o_spi_burst_count), 32'd4);
    check_eq("b_wr_empty", 32'(o_spi_data), 32'd0);
    spi_end();
    check_eq("b_burst_en_clr", 32'(o_spi_burst_enable), 32'd0);
    check_eq("b_underrun", 32'(o_underrun), 32'd0);

    // Three-word read burst
    issue_cmd(15'h0200, 1'b1, 16'd3);
    wait_enable();
    check_eq("c_rw", 32'(o_spi_rw), 32'd1);
    check_eq("c_burst_cnt", 32'(o_spi_burst_count), 32'd3);
    spi_start(1'b0);
    spi_read_word(16'hA0A0, 1'b1);
    spi_read_word(16'hB1B1, 1'b1);
    spi_read_word(16'hC2C2, 1'b1);
    spi_end();
    drain_rd();
    check_eq("c_overflow", 32'(o_overflow), 32'd0);

    // Write underrun: three words requested, one supplied
    host_push(16'h55AA);
    issue_cmd(15'h0300, 1'b0, 16'd3);
    wait_enable();
    spi_start(1'b1);
    check_eq("d_underrun_pre", 32'(o_underrun), 32'd0);
    spi_request(1'b0);
    spi_request(1'b0);
    check_eq("d_underrun", 32'(o_underrun), ERR_EN);
    i_err_clear = 1'b1;
    tick();
    i_err_clear = 1'b0;
    check_eq("d_underrun_clr", 32'(o_underrun), 32'd0);
    spi_end();

    // Oversized read is never accepted; zero-length command does nothing on SPI
    i_cmd_addr = 15'h0; i_cmd_rw = 1'b1; i_cmd_len = 16'd20; i_cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_eq("e_len20_ready", 32'(o_cmd_ready), 32'd0);
    check_eq("e_len20_enable", 32'(o_spi_enable), 32'd0);
    check_eq("e_len20_idle", 32'(o_idle), 32'd1);
    i_cmd_valid = 1'b0;
    #1;
    check_eq("e_ready_back", 32'(o_cmd_ready), 32'd1);
    issue_cmd(15'h0400, 1'b0, 16'd0);
    check_eq("e_len0_done", 32'(o_idle), 32'd0);
    check_eq("e_len0_enable", 32'(o_spi_enable), 32'd0);
    tick();
    check_eq("e_len0_idle", 32'(o_idle), 32'd1);
    check_eq("e_len0_enable2", 32'(o_spi_enable), 32'd0);

    // Full-depth read plus one extra word: last word dropped
    issue_cmd(15'h0500, 1'b1, 16'd16);
    wait_enable();
    spi_start(1'b0);
    for (int i = 0; i < 17; i++) spi_read_word(DW'(16'h7000 + i), (i < 16));
    check_eq("f_overflow", 32'(o_overflow), ERR_EN);
    spi_end();
    i_cmd_rw = 1'b1; i_cmd_len = 16'd1; i_cmd_valid = 1'b1;
    #1;
    check_eq("f_full_rd_ready", 32'(o_cmd_ready), 32'd0);
    i_cmd_rw = 1'b0;
    #1;
    check_eq("f_full_wr_ready", 32'(o_cmd_ready), 32'd1);
    i_cmd_valid = 1'b0;
    drain_rd();
    i_err_clear = 1'b1;
    tick();
    i_err_clear = 1'b0;
    check_eq("f_overflow_clr", 32'(o_overflow), 32'd0);

    // Single-word read pushed on busy fall
    issue_cmd(15'h0600, 1'b1, 16'd1);
    wait_enable();
    check_eq("g_burst_en", 32'(o_spi_burst_enable), 32'd0);
    spi_start(1'b0);
    i_spi_read_word = 16'h1357;
    rd_q.push_back(16'h1357);
    i_spi_busy = 1'b0;
    tick();
    check_eq("g_rd_valid", 32'(o_rd_valid), 32'd1);
    check_eq("g_rd_data", 32'(o_rd_data), 32'(rd_q[0]));
    wait_idle();

    // Reset in the middle of a four-word write burst
    for (int i = 0; i < 4; i++) host_push(DW'(16'h0A00 + i));
    issue_cmd(15'h0700, 1'b0, 16'd4);
    wait_enable();
    spi_start(1'b1);
    spi_request(1'b1);
    i_rst = 1'b1;
    tick();
    check_eq("h_enable", 32'(o_spi_enable), 32'd0);
    check_eq("h_idle", 32'(o_idle), 32'd1);
    check_eq("h_rd_valid", 32'(o_rd_valid), 32'd0);
    check_eq("h_wr_ready", 32'(o_wr_ready), 32'd1);
    check_eq("h_spi_data", 32'(o_spi_data), 32'd0);
    check_eq("h_burst_en", 32'(o_spi_burst_enable), 32'd0);
    i_spi_busy = 1'b0;
    i_rst = 1'b0;
    wr_q.delete();
    rd_q.delete();
    tick();
    host_push(16'h2468);
    check_eq("h_fresh_head", 32'(o_spi_data), 32'h2468);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
